// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg                                                             |
// | Shared glyph constants and nibble-to-glyph helper (active-low).      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t GLYPH_0 = 7'h40;
  localparam seg_t GLYPH_1 = 7'h79;
  localparam seg_t GLYPH_2 = 7'h24;
  localparam seg_t GLYPH_3 = 7'h30;
  localparam seg_t GLYPH_4 = 7'h19;
  localparam seg_t GLYPH_5 = 7'h12;
  localparam seg_t GLYPH_6 = 7'h02;
  localparam seg_t GLYPH_7 = 7'h78;
  localparam seg_t GLYPH_8 = 7'h00;
  localparam seg_t GLYPH_9 = 7'h10;
  localparam seg_t GLYPH_A = 7'h08;
  localparam seg_t GLYPH_B = 7'h03;
  localparam seg_t GLYPH_C = 7'h46;
  localparam seg_t GLYPH_D = 7'h21;
  localparam seg_t GLYPH_E = 7'h06;
  localparam seg_t GLYPH_F = 7'h0E;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t r_glyph;
    case (nibble)
      4'h0:    r_glyph = GLYPH_0;
      4'h1:    r_glyph = GLYPH_1;
      4'h2:    r_glyph = GLYPH_2;
      4'h3:    r_glyph = GLYPH_3;
      4'h4:    r_glyph = GLYPH_4;
      4'h5:    r_glyph = GLYPH_5;
      4'h6:    r_glyph = GLYPH_6;
      4'h7:    r_glyph = GLYPH_7;
      4'h8:    r_glyph = GLYPH_8;
      4'h9:    r_glyph = GLYPH_9;
      4'hA:    r_glyph = GLYPH_A;
      4'hB:    r_glyph = GLYPH_B;
      4'hC:    r_glyph = GLYPH_C;
      4'hD:    r_glyph = GLYPH_D;
      4'hE:    r_glyph = GLYPH_E;
      default: r_glyph = GLYPH_F;
    endcase
    return r_glyph;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_hex_lut.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_hex_lut                                                         |
// | Combinational hex nibble to active-low seven-segment glyph.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_scan_driver                                                     |
// | Multiplexed common-anode hex display driver with per-frame snapshot. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lead,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp
);

  localparam int c_IDX_W = $clog2(NUM_DIGITS);
  localparam int c_DIV_W = $clog2(REFRESH_DIV);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

  logic [c_DIV_W-1:0]      r_div_cnt;
  logic [c_IDX_W-1:0]      r_digit_idx;
  logic [4*NUM_DIGITS-1:0] r_frame_val;
  logic [NUM_DIGITS-1:0]   r_frame_dp;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_dp;

  logic                    w_tick;
  logic [3:0]              w_nibble;
  logic [6:0]              w_glyph;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an;
  logic                    w_dp;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_zero_from;

  assign w_tick = (r_div_cnt == c_DIV_LAST);

  // w_zero_from[i]: every nibble from digit i up to the leftmost is zero
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
    assign w_zero_from[gi] = (r_frame_val[4*NUM_DIGITS-1:4*gi] == '0);
  end

  always_comb begin
    w_nibble = '0;
    w_an     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_digit_idx == c_IDX_W'(i)) begin
        w_nibble = r_frame_val[4*i +: 4];
        w_an[i]  = 1'b0;
      end
    end
    w_blank = blank_lead && (r_digit_idx != '0) && w_zero_from[r_digit_idx];
    w_seg   = w_blank ? SEG_BLANK : w_glyph;
    w_dp    = ~r_frame_dp[r_digit_idx];
  end

  seg7_hex_lut u_lut (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
      r_frame_val <= value;
      r_frame_dp  <= dp_in;
      r_seg       <= SEG_BLANK;
      r_an        <= '1;
      r_dp        <= 1'b1;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
      if (w_tick) begin
        if (r_digit_idx == c_IDX_LAST) begin
          // Frame boundary: snapshot so one frame never mixes two values
          r_digit_idx <= '0;
          r_frame_val <= value;
          r_frame_dp  <= dp_in;
        end else begin
          r_digit_idx <= r_digit_idx + 1'b1;
        end
      end
      r_seg <= w_seg;
      r_an  <= w_an;
      r_dp  <= w_dp;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg7_scan_driver                                                  |
// | Randomized self-checking bench with a cycle-count reference model.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_seg7_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   value;
  logic [3:0]    dp_in;
  logic          blank_lead;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic          dp;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [6:0]  glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] m_frame;
  logic [3:0]  m_fdp;
  int          m_t;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic        exp_dp;

  seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lead (blank_lead),
    .seg        (seg),
    .an         (an),
    .dp         (dp)
  );

  always #5 clk = ~clk;

  // Model: after release, edge t shows digit (t/DIV)%ND; the frame reloads on the last edge of a frame.
  task automatic step();
    int d;
    logic [15:0] sh;
    logic blank;
    if (reset) begin
      exp_seg = 7'h7F;
      exp_an  = 4'hF;
      exp_dp  = 1'b1;
      m_frame = value;
      m_fdp   = dp_in;
      m_t     = 0;
    end else begin
      d       = (m_t / DIV) % ND;
      sh      = m_frame >> (4 * d);
      blank   = blank_lead && (d > 0) && (sh == 16'h0);
      exp_seg = blank ? 7'h7F : glyph[sh[3:0]];
      exp_an  = 4'hF & ~(4'b0001 << d);
      exp_dp  = ~m_fdp[d];
      if (m_t % (DIV * ND) == DIV * ND - 1) begin
        m_frame = value;
        m_fdp   = dp_in;
      end
      m_t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    value = 16'h1234; dp_in = 4'h0; blank_lead = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({seg, an, dp} !== {7'h7F, 4'hF, 1'b1} || {seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        n_err++;
        $display("FAIL reset_hold: seg=%h an=%b dp=%b want seg=7f an=1111 dp=1", seg, an, dp);
      end
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (an !== 4'b1110 || seg !== 7'h19 || {seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
      n_err++;
      $display("FAIL reset_release: seg=%h an=%b want seg=19 an=1110", seg, an);
    end
  endtask

  task automatic test_steady_scan();
    logic [6:0] lit;
    for (int i = 0; i < 32; i++) begin
      step();
      case (an)
        4'b1110: lit = 7'h19;
        4'b1101: lit = 7'h30;
        4'b1011: lit = 7'h24;
        4'b0111: lit = 7'h79;
        default: lit = 7'hxx;
      endcase
      n_cmp++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp} || seg !== lit || dp !== 1'b1) begin
        n_err++;
        $display("FAIL steady_scan: seg=%h an=%b dp=%b want seg=%h an=%b dp=%b",
                 seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
  endtask

  task automatic test_mid_frame();
    logic [6:0] seq [$];
    logic [6:0] want [6];
    logic [3:0] prev_an;
    bit found = 0;
    want = '{7'h24, 7'h79, 7'h21, 7'h46, 7'h03, 7'h08};
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (an === 4'b1011) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_frame_wait: an=%b never reached 1011 within 40 cycles", an);
    end else begin
      value = 16'hABCD;
      seq.push_back(seg);
      prev_an = an;
      for (int i = 0; i < 24; i++) begin
        step();
        n_cmp++;
        if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
          n_err++;
          $display("FAIL mid_frame_scan: seg=%h an=%b want seg=%h an=%b", seg, an, exp_seg, exp_an);
        end
        if (an !== prev_an) seq.push_back(seg);
        prev_an = an;
      end
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (k >= seq.size() || seq[k] !== want[k]) begin
          n_err++;
          $display("FAIL mid_frame_seq[%0d]: got %h want %h", k, (k < seq.size()) ? seq[k] : 7'hxx, want[k]);
        end
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] lit;
    blank_lead = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      value = (pass == 0) ? 16'h0050 : 16'h0000;
      for (int i = 0; i < 32; i++) begin
        step();
        if (an === 4'b1110)      lit = 7'h40;
        else if (an === 4'b1101) lit = (pass == 0) ? 7'h12 : 7'h7F;
        else                     lit = 7'h7F;
        n_cmp++;
        if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp} || (i >= 16 && seg !== lit)) begin
          n_err++;
          $display("FAIL blanking: value=%h seg=%h an=%b want seg=%h an=%b",
                   value, seg, an, exp_seg, exp_an);
        end
      end
    end
  endtask

  task automatic test_decimal_point();
    dp_in = 4'b0100;
    for (int i = 0; i < 32; i++) begin
      step();
      n_cmp++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp} ||
          (i >= 16 && (dp !== (an !== 4'b1011) || (an === 4'b1011 && seg !== 7'h7F)))) begin
        n_err++;
        $display("FAIL decimal_point: an=%b dp=%b seg=%h want dp=%b seg=%h", an, dp, seg, exp_dp, exp_seg);
      end
    end
    dp_in = 4'h0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (an === 4'b1011) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL reset_mid_wait: an=%b never reached 1011 within 40 cycles", an);
    end else begin
      value = 16'($urandom);
      reset = 1'b1;
      step();
      n_cmp++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        n_err++;
        $display("FAIL reset_mid_off: seg=%h an=%b dp=%b want seg=7f an=1111 dp=1", seg, an, dp);
      end
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        n_cmp++;
        if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp} ||
            (i < 4 && (an !== 4'b1110 || seg !== glyph[value[3:0]])) ||
            (i == 4 && an !== 4'b1101)) begin
          n_err++;
          $display("FAIL reset_mid_dwell[%0d]: seg=%h an=%b want seg=%h an=%b",
                   i, seg, an, exp_seg, exp_an);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) value = 16'($urandom);
      if ($urandom_range(7) == 0) value = 16'($urandom_range(255));
      if ($urandom_range(15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(15) == 0) blank_lead = 1'($urandom);
      reset = ($urandom_range(63) == 0);
      step();
      n_cmp++;
      if ({seg, an, dp} !== {exp_seg, exp_an, exp_dp}) begin
        n_err++;
        $display("FAIL random[%0d]: seg=%h an=%b dp=%b want seg=%h an=%b dp=%b",
                 i, seg, an, dp, exp_seg, exp_an, exp_dp);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; value = 16'h0; dp_in = 4'h0; blank_lead = 1'b0;
    m_frame = 16'h0; m_fdp = 4'h0; m_t = 0;
    exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1;
    test_reset();
    test_steady_scan();
    test_mid_frame();
    test_blanking();
    test_decimal_point();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Drives a time-multiplexed, common-anode, active-low hex seven-segment display from a packed binary value, such as the count from the team's counters or the ALU result.
- Performs the inverse of the switch-level encoders: it turns binary nibbles into glyph and digit-strobe patterns.
- Sits between datapath registers and the board display pins.
- Internal refresh divider, digit scanner and per-frame value snapshot, so the displayed frame never mixes two values.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 2..8.
- REFRESH_DIV, 50000: clk cycles each digit is strobed; minimum 2. The bench uses 4.

Ports:
- clk  in  1: system clock, all logic on its rising edge.
- reset  in  1: synchronous, active-high.
- value  in  4*NUM_DIGITS: packed hex value; nibble i is shown on digit i, with digit 0 rightmost.
- dp_in  in  NUM_DIGITS: decimal point request per digit, active-high.
- blank_lead  in  1: 1 enables leading-zero blanking.
- seg  out  7: segments {g,f,e,d,c,b,a}, active-low.
- an  out  NUM_DIGITS: digit strobes, one-hot active-low.
- dp  out  1: decimal point, active-low.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - div_cnt=0, digit_idx=0.
  - seg=7'h7F, an=all ones, dp=1.
  - frame_val<=value and frame_dp<=dp_in every reset cycle, so the snapshot tracks the inputs while in reset.
- Divider: div_cnt counts 0..REFRESH_DIV-1 and wraps. tick = (div_cnt==REFRESH_DIV-1).
- Scanner:
  - On tick, digit_idx advances and wraps from NUM_DIGITS-1 to 0.
  - On the tick that wraps to 0, frame_val<=value and frame_dp<=dp_in.
  - value and dp_in are sampled only at frame boundaries. Mid-frame changes have no effect until the next frame.
- Output stage:
  - seg, an and dp are registered from digit_idx, frame_val and frame_dp, giving a one-cycle latency from a digit_idx change.
  - Each digit dwells exactly REFRESH_DIV cycles.
  - The first edge with reset low loads digit 0 outputs.
- Strobe: an[digit_idx]=0, all other bits 1.
- Glyph table (active-low hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Blanking:
  - With blank_lead=1, digit i>0 is blanked when frame_val nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - A blanked digit drives seg=7F, keeps its strobe active, and dp still follows frame_dp.
- dp: dp = ~frame_dp[digit_idx].
- blank_lead is used combinationally at the output stage and is not snapshotted.
- Reset mid-operation: on the next edge outputs go off, idx=0 and div=0. After release, scanning restarts at digit 0 with a full dwell.
- Widths: digit_idx is $clog2(NUM_DIGITS) bits. div_cnt is $clog2(REFRESH_DIV) bits. No arithmetic overflow is possible.
- No X on outputs after the first reset edge.

Decomposition:
- Package seg7_pkg:
  - SEG_BLANK constant (7'h7F).
  - Glyph constants 0..F.
  - Function hex_to_seg(nibble).
- Sub-module seg7_hex_lut: combinational nibble to active-low glyph, instantiated once on the selected nibble.
- Divider and scanner stay in the top module.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
- Reset: hold reset 3 cycles with value=16'h1234 -> seg=7F, an=1111, dp=1 throughout. The first edge with reset low gives an=1110, seg=19.
- Steady scan: value=16'h1234, blank_lead=0, dp_in=0 -> an sequence 1110, 1101, 1011, 0111, each held 4 cycles, with seg 19, 30, 24, 79. The pattern repeats every 16 cycles and dp stays 1.
- Mid-frame change: switch to 16'hABCD while an=1011 -> this frame still shows 24 then 79. The next frame shows 21, 46, 03, 08.
- Blanking: blank_lead=1, value=16'h0050 -> digits 3 and 2 seg=7F, digit 1 seg=12, digit 0 seg=40. With value=0, only digit 0 shows 40.
- Decimal point: dp_in=4'b0100 -> dp=0 only while an=1011, including when digit 2 is blanked.
- Mid-operation reset: assert reset for 1 cycle while an=1011 -> the next edge gives an=1111. After release: an=1110 with a full 4-cycle dwell, and frame_val equals value at release.
